// File: rtl/mem_pkg.sv
// Shared widths, latencies and FSM encoding for the memory module
// (ram_access_unit and the cache controller's RAM port).
package mem_pkg;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_READ_LAT  = 4;
  localparam int DEF_WRITE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2,
    RD_DONE = 2'd3
  } state_t;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/ram_access_unit_if.sv
// Cache-controller <-> backing-store RAM port.
interface ram_access_unit_if
  import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic              rd_en;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              data_ready;
    logic              busy;
    logic              req_err;

    modport master (output rd_en, wr_en, addr, wdata,
                    input  rdata, data_ready, busy, req_err);
    modport slave  (input  rd_en, wr_en, addr, wdata,
                    output rdata, data_ready, busy, req_err);
endinterface

// File: rtl/main_mem_array.sv
// DEPTH x DATA_W storage: synchronous write, registered read.
// Only the read register is reset; array contents survive reset.
module main_mem_array
  import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              re,
    output logic [DATA_W-1:0] rdata_q
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata_q <= '0;
        else if (re) rdata_q <= mem[raddr];
    end
endmodule

// File: rtl/ram_access_unit.sv
// Backing store behind the cache controller: posted writes, fixed-latency
// reads, one pending slot per request type.
module ram_access_unit
  import mem_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int READ_LAT  = DEF_READ_LAT,
    parameter int WRITE_LAT = DEF_WRITE_LAT
) (
    input logic             clk,
    input logic             rst_n,
    ram_access_unit_if.slave bus
);
    localparam int CNT_W = $clog2(max_lat(READ_LAT, WRITE_LAT)) + 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_LAT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              rd_en_q, wr_en_q;
    logic              rd_pend, wr_pend;
    logic [ADDR_W-1:0] cur_addr, rd_addr_p, wr_addr_p;
    logic [DATA_W-1:0] cur_wdata, wr_data_p;
    logic              data_ready_r, req_err_r;
    logic              rd_req, wr_req, rd_acc, both_req;
    logic              wr_last, rd_last;

    assign rd_req   = bus.rd_en & ~rd_en_q;
    assign wr_req   = bus.wr_en & ~wr_en_q;
    // On a simultaneous rise the write wins and the read is discarded.
    assign both_req = rd_req & wr_req;
    assign rd_acc   = rd_req & ~wr_req;
    assign wr_last  = (state == WR_BUSY) && (cnt == WR_LAST);
    // Array read is issued on the last busy cycle so rdata lands with data_ready.
    assign rd_last  = (state == RD_BUSY) && (cnt == RD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_pend      <= 1'b0;
            wr_pend      <= 1'b0;
            cur_addr     <= '0;
            rd_addr_p    <= '0;
            wr_addr_p    <= '0;
            cur_wdata    <= '0;
            wr_data_p    <= '0;
            data_ready_r <= 1'b0;
            req_err_r    <= 1'b0;
        end else begin
            rd_en_q      <= bus.rd_en;
            wr_en_q      <= bus.wr_en;
            data_ready_r <= 1'b0;
            req_err_r    <= both_req;
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        state     <= WR_BUSY;
                        cnt       <= '0;
                        cur_addr  <= bus.addr;
                        cur_wdata <= bus.wdata;
                    end else if (rd_acc) begin
                        state    <= RD_BUSY;
                        cnt      <= '0;
                        cur_addr <= bus.addr;
                    end
                end
                WR_BUSY: begin
                    if (wr_req) req_err_r <= 1'b1;
                    if (!wr_last) begin
                        cnt <= cnt + 1'b1;
                        if (rd_acc) begin
                            if (rd_pend) req_err_r <= 1'b1;
                            else begin
                                rd_pend   <= 1'b1;
                                rd_addr_p <= bus.addr;
                            end
                        end
                    end else begin
                        cnt <= '0;
                        if (rd_pend) begin
                            state    <= RD_BUSY;
                            cur_addr <= rd_addr_p;
                            rd_pend  <= 1'b0;
                            if (rd_acc) req_err_r <= 1'b1;
                        end else if (rd_acc) begin
                            state    <= RD_BUSY;
                            cur_addr <= bus.addr;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RD_BUSY: begin
                    if (rd_acc) req_err_r <= 1'b1;
                    if (wr_req) begin
                        if (wr_pend) req_err_r <= 1'b1;
                        else begin
                            wr_pend   <= 1'b1;
                            wr_addr_p <= bus.addr;
                            wr_data_p <= bus.wdata;
                        end
                    end
                    if (!rd_last) cnt <= cnt + 1'b1;
                    else begin
                        cnt          <= '0;
                        state        <= RD_DONE;
                        data_ready_r <= 1'b1;
                    end
                end
                RD_DONE: begin
                    if (rd_acc) req_err_r <= 1'b1;
                    if (wr_pend) begin
                        state     <= WR_BUSY;
                        cur_addr  <= wr_addr_p;
                        cur_wdata <= wr_data_p;
                        wr_pend   <= 1'b0;
                        if (wr_req) req_err_r <= 1'b1;
                    end else if (wr_req) begin
                        state     <= WR_BUSY;
                        cur_addr  <= bus.addr;
                        cur_wdata <= bus.wdata;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    main_mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_last),
        .waddr  (cur_addr),
        .wdata  (cur_wdata),
        .raddr  (cur_addr),
        .re     (rd_last),
        .rdata_q(bus.rdata)
    );

    assign bus.data_ready = data_ready_r;
    assign bus.req_err    = req_err_r;
    assign bus.busy       = (state != IDLE) | rd_pend | wr_pend;
endmodule
